// File: rtl/mlkem_pkg.sv
// Shared ML-KEM definitions for the encode/decode/compress pipeline stages.
//   Q       : the ML-KEM modulus 3329
//   N       : coefficients per polynomial (256)
//   coef_t  : one 12-bit coefficient
//   state_e : two-state frame controller used by the streaming stages
package mlkem_pkg;

  localparam int unsigned Q = 3329;
  localparam int unsigned N = 256;

  typedef logic [11:0] coef_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/cond_sub_q.sv
// Single conditional subtraction of q. The output is fully reduced
// whenever the input is below 2*q, which is the case for any 12-bit value.
// Ports:
//   a_i : 12-bit value in [0, 2q)
//   r_o : a_i mod q
module cond_sub_q
  import mlkem_pkg::*;
(
  input  logic [11:0] a_i,
  output logic [11:0] r_o
);

  localparam logic [11:0] Q_C = 12'(Q);

  assign r_o = (a_i >= Q_C) ? (a_i - Q_C) : a_i;

endmodule

// File: rtl/byte_decode_stream.sv
// Streaming ByteDecode_d. Consumes one frame of 32*D bytes (LSB-first bit
// order) and emits 256 D-bit coefficients, one per output handshake. For
// D = 12 each coefficient is reduced mod q.
// Ports:
//   clk_i, rst_ni                : clock, synchronous active-low reset
//   start_i                      : begin a frame (only honoured in IDLE)
//   in_data_i/valid_i/ready_o    : byte input stream
//   coef_o/idx_o/last_o/valid_o  : coefficient output stream
//   coef_ready_i                 : output stream ready
//   busy_o                       : frame in progress
//   done_o                       : one-cycle pulse after the final coefficient
module byte_decode_stream
  import mlkem_pkg::*;
#(
  parameter int D         = 12,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [7:0]           in_data_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [OUT_WIDTH-1:0] coef_o,
  output logic [7:0]           coef_idx_o,
  output logic                 coef_last_o,
  output logic                 coef_valid_o,
  input  logic                 coef_ready_i,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int BUF_W = D + 8;
  localparam int CNT_W = $clog2(D + 9);

  localparam logic [CNT_W-1:0] D_C           = CNT_W'(D);
  localparam logic [CNT_W-1:0] BYTE_BITS_C   = CNT_W'(8);
  localparam logic [8:0]       FRAME_BYTES_C = 9'(32 * D);
  localparam logic [8:0]       LAST_IDX_C    = 9'(N - 1);

  state_e             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [8:0]         byte_cnt_q, byte_cnt_d;
  logic [8:0]         coef_cnt_q, coef_cnt_d;
  logic               done_q, done_d;

  logic               push;
  logic               pop;
  logic [CNT_W-1:0]   wr_pos;
  logic [BUF_W-1:0]   byte_ext;
  logic [D-1:0]       raw;

  // Accepting a byte only while at most D bits are buffered keeps bit_cnt
  // within D+8, and bit_cnt < D always leaves room for a byte.
  assign in_ready_o   = (state_q == RUN) && (byte_cnt_q < FRAME_BYTES_C)
                        && (bit_cnt_q <= D_C);
  assign coef_valid_o = (state_q == RUN) && (bit_cnt_q >= D_C);

  assign push     = in_valid_i && in_ready_o;
  assign pop      = coef_valid_o && coef_ready_i;
  assign byte_ext = BUF_W'(in_data_i);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    buf_d      = buf_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    coef_cnt_d = coef_cnt_q;
    done_d     = 1'b0;
    wr_pos     = bit_cnt_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = RUN;
          buf_d      = '0;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          coef_cnt_d = '0;
        end
      end

      RUN: begin
        if (pop) begin
          buf_d      = buf_q >> D;
          bit_cnt_d  = bit_cnt_q - D_C;
          coef_cnt_d = coef_cnt_q + 9'd1;
          wr_pos     = bit_cnt_q - D_C;
          if (coef_cnt_q == LAST_IDX_C) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        // Bits above bit_cnt are always zero (cleared on start, zero-filled
        // by the shift), so the new byte can simply be OR-ed into place.
        if (push) begin
          buf_d      = buf_d | (byte_ext << wr_pos);
          bit_cnt_d  = bit_cnt_d + BYTE_BITS_C;
          byte_cnt_d = byte_cnt_q + 9'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      // NOTE: the bit buffer is a handful of flops, not a RAM, so resetting
      // it is cheap and guarantees coef_o reads 0 out of reset.
      buf_q      <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      coef_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // computed from the previous state, independent of statement order.
      state_q    <= state_d;
      buf_q      <= buf_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      coef_cnt_q <= coef_cnt_d;
      done_q     <= done_d;
    end
  end

  assign raw = buf_q[D-1:0];

  generate
    if (D == 12) begin : g_reduce
      logic [11:0] reduced;
      cond_sub_q u_cond_sub_q (
        .a_i (raw),
        .r_o (reduced)
      );
      assign coef_o = OUT_WIDTH'(reduced);
    end else begin : g_plain
      assign coef_o = OUT_WIDTH'(raw);
    end
  endgenerate

  assign coef_idx_o  = coef_cnt_q[7:0];
  assign coef_last_o = coef_valid_o && (coef_cnt_q == LAST_IDX_C);
  assign busy_o      = (state_q == RUN);
  assign done_o      = done_q;

endmodule

// File: tb/tb_byte_decode_stream.sv
// Self-checking bench for byte_decode_stream. Three instances (D = 12, 1, 8)
// share the input stream; each is started individually and a selector routes
// the active instance's outputs to the checking tasks.
module tb_byte_decode_stream;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [7:0]  in_data_i;
  logic        in_valid_i;
  logic        coef_ready_i;

  logic        start_w    [3];
  logic        in_ready_w [3];
  logic [15:0] coef_w     [3];
  logic [7:0]  idx_w      [3];
  logic        last_w     [3];
  logic        valid_w    [3];
  logic        busy_w     [3];
  logic        done_w     [3];

  always #5 clk_i = ~clk_i;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DG = (g == 0) ? 12 : ((g == 1) ? 1 : 8);
    byte_decode_stream #(.D(DG), .OUT_WIDTH(16)) u_dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .start_i      (start_w[g]),
      .in_data_i    (in_data_i),
      .in_valid_i   (in_valid_i),
      .in_ready_o   (in_ready_w[g]),
      .coef_o       (coef_w[g]),
      .coef_idx_o   (idx_w[g]),
      .coef_last_o  (last_w[g]),
      .coef_valid_o (valid_w[g]),
      .coef_ready_i (coef_ready_i),
      .busy_o       (busy_w[g]),
      .done_o       (done_w[g])
    );
  end

  logic [1:0]  sel;
  logic        s_ready, s_valid, s_last, s_busy, s_done;
  logic [15:0] s_coef;
  logic [7:0]  s_idx;

  always_comb begin
    s_ready = in_ready_w[sel];
    s_valid = valid_w[sel];
    s_last  = last_w[sel];
    s_busy  = busy_w[sel];
    s_done  = done_w[sel];
    s_coef  = coef_w[sel];
    s_idx   = idx_w[sel];
  end

  logic [7:0]  stim_bytes [384];
  int          n_bytes;
  int unsigned exp_coef   [256];
  int unsigned sb_q       [$];
  int          vectors;
  int          miscompares;

  function automatic int d_of(input logic [1:0] s);
    case (s)
      2'd0:    return 12;
      2'd1:    return 1;
      default: return 8;
    endcase
  endfunction

  // Start instance s: one-cycle start pulse, then RUN must be visible.
  task automatic start_frame(input logic [1:0] s);
    sel = s;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    start_w[s] = 1'b1;
    @(negedge clk_i);
    start_w[s] = 1'b0;
    vectors++;
    if ({s_busy, s_ready, s_valid, s_idx} !== {1'b1, 1'b1, 1'b0, 8'd0}) begin
      miscompares++;
      $display("FAIL start_run: busy/ready/valid/idx got %b/%b/%b/%0d expected 1/1/0/0",
               s_busy, s_ready, s_valid, s_idx);
    end
  endtask

  // Streams stim_bytes into the selected instance and scoreboards coefficients.
  // Expected coefficients are queued as soon as enough stream bits have been
  // accepted to define them. Returns at the done_o cycle, or after stop_coefs
  // handshakes when stop_coefs < 256.
  task automatic run_frame(input logic [1:0] s, input int stop_coefs,
                           input bit rand_valid, input bit toggle_ready);
    int          d, acc, seen, pushed, avail, cyc;
    bit          prev_stall, last_hs_prev, exp_ready, exp_valid;
    logic [15:0] held_coef;
    logic [7:0]  held_idx;
    int unsigned exp_v;
    d = d_of(s);
    sel = s;
    acc = 0; seen = 0; pushed = 0; cyc = 0;
    prev_stall = 1'b0; last_hs_prev = 1'b0;
    held_coef = '0; held_idx = '0;
    sb_q.delete();
    while (1) begin
      @(negedge clk_i);
      cyc++;
      avail = 8 * acc - d * seen;

      vectors++;
      if (s_done !== last_hs_prev) begin
        miscompares++;
        $display("FAIL done_pulse d=%0d: got %b expected %b at coef %0d", d, s_done, last_hs_prev, seen);
      end
      if (last_hs_prev) begin
        vectors++;
        if (s_busy !== 1'b0) begin
          miscompares++;
          $display("FAIL busy_at_done d=%0d: got %b expected 0", d, s_busy);
        end
        break;
      end
      if (stop_coefs < 256 && seen == stop_coefs) break;
      if (cyc > 4000) begin
        vectors++;
        miscompares++;
        $display("FAIL timeout d=%0d: got %0d coefs expected 256", d, seen);
        break;
      end

      exp_ready = (acc < 32 * d) && (avail <= d);
      exp_valid = (avail >= d);
      vectors++;
      if ({s_ready, s_valid} !== {exp_ready, exp_valid}) begin
        miscompares++;
        $display("FAIL flow_ctrl d=%0d cyc=%0d: ready/valid got %b/%b expected %b/%b",
                 d, cyc, s_ready, s_valid, exp_ready, exp_valid);
      end
      if (prev_stall) begin
        vectors++;
        if ({s_coef, s_idx} !== {held_coef, held_idx}) begin
          miscompares++;
          $display("FAIL stall_hold d=%0d: coef/idx got %0d/%0d expected %0d/%0d",
                   d, s_coef, s_idx, held_coef, held_idx);
        end
      end

      in_valid_i   = (acc < n_bytes) && (!rand_valid || $urandom_range(0, 3) != 0);
      in_data_i    = (acc < n_bytes) ? stim_bytes[acc] : 8'h00;
      coef_ready_i = toggle_ready ? cyc[0] : 1'b1;

      if (in_valid_i && s_ready) begin
        acc++;
        while (pushed < 256 && 8 * acc >= (pushed + 1) * d) begin
          sb_q.push_back(exp_coef[pushed]);
          pushed++;
        end
      end

      last_hs_prev = 1'b0;
      if (s_valid && coef_ready_i) begin
        vectors++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL early_coef d=%0d: got coef at idx %0d expected none yet", d, s_idx);
        end else begin
          exp_v = sb_q.pop_front();
          if ({s_coef, s_idx, s_last} !== {16'(exp_v), 8'(seen), (seen == 255)}) begin
            miscompares++;
            $display("FAIL coef d=%0d: coef/idx/last got %0d/%0d/%b expected %0d/%0d/%b",
                     d, s_coef, s_idx, s_last, exp_v, seen, (seen == 255));
          end
        end
        seen++;
        last_hs_prev = (seen == 256);
      end
      prev_stall = s_valid && !coef_ready_i;
      held_coef  = s_coef;
      held_idx   = s_idx;
    end
    in_valid_i = 1'b0;
    if (stop_coefs >= 256) begin
      vectors++;
      if (acc !== n_bytes || sb_q.size() != 0) begin
        miscompares++;
        $display("FAIL byte_count d=%0d: got %0d bytes, %0d unmatched expected %0d bytes, 0 unmatched",
                 d, acc, sb_q.size(), n_bytes);
      end
    end
  endtask

  task automatic build_d12_ramp();
    n_bytes = 384;
    for (int i = 0; i < 384; i++) stim_bytes[i] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      automatic int unsigned f = i % 3329;
      exp_coef[i] = f;
      for (int b = 0; b < 12; b++) begin
        automatic int pos = i * 12 + b;
        stim_bytes[pos / 8][pos % 8] = f[b];
      end
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    for (int s = 0; s < 3; s++) begin
      vectors++;
      if ({in_ready_w[s], valid_w[s], last_w[s], busy_w[s], done_w[s], coef_w[s], idx_w[s]} !== '0) begin
        miscompares++;
        $display("FAIL reset_state inst=%0d: got ready=%b valid=%b busy=%b coef=%0d expected all 0",
                 s, in_ready_w[s], valid_w[s], busy_w[s], coef_w[s]);
      end
    end
    rst_ni = 1'b1;
  endtask

  task automatic test_d12_round_trip();
    build_d12_ramp();
    start_frame(2'd0);
    run_frame(2'd0, 256, 1'b0, 1'b0);
  endtask

  task automatic test_d12_reduction();
    n_bytes = 384;
    for (int i = 0; i < 384; i++) stim_bytes[i] = 8'hFF;
    for (int i = 0; i < 256; i++) exp_coef[i] = 766;
    start_frame(2'd0);
    run_frame(2'd0, 256, 1'b0, 1'b0);
  endtask

  task automatic test_d1_pattern();
    n_bytes = 32;
    for (int i = 0; i < 32; i++) stim_bytes[i] = 8'h55;
    for (int i = 0; i < 256; i++) exp_coef[i] = (i % 2 == 0) ? 1 : 0;
    start_frame(2'd1);
    run_frame(2'd1, 256, 1'b0, 1'b0);
  endtask

  task automatic build_d8_ramp();
    n_bytes = 256;
    for (int i = 0; i < 256; i++) begin
      stim_bytes[i] = 8'(i);
      exp_coef[i]   = i;
    end
  endtask

  task automatic test_d8_backpressure();
    build_d8_ramp();
    start_frame(2'd2);
    run_frame(2'd2, 256, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    build_d12_ramp();
    start_frame(2'd0);
    run_frame(2'd0, 100, 1'b0, 1'b0);
    rst_ni     = 1'b0;
    in_valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    vectors++;
    if ({s_ready, s_valid, s_last, s_busy, s_done, s_coef, s_idx} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: got ready=%b valid=%b busy=%b coef=%0d idx=%0d expected all 0",
               s_ready, s_valid, s_busy, s_coef, s_idx);
    end
    start_frame(2'd0);
    run_frame(2'd0, 256, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    build_d8_ramp();
    sel = 2'd2;
    @(negedge clk_i);
    start_w[2] = 1'b1;
    @(negedge clk_i);
    // start_i stays high for the whole frame and must not disturb it.
    run_frame(2'd2, 256, 1'b0, 1'b0);
    @(negedge clk_i);
    vectors++;
    if ({s_busy, s_ready, s_idx} !== {1'b1, 1'b1, 8'd0}) begin
      miscompares++;
      $display("FAIL restart: busy/ready/idx got %b/%b/%0d expected 1/1/0", s_busy, s_ready, s_idx);
    end
    start_w[2] = 1'b0;
    run_frame(2'd2, 256, 1'b1, 1'b1);
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    sel          = 2'd0;
    rst_ni       = 1'b0;
    in_data_i    = 8'h00;
    in_valid_i   = 1'b0;
    coef_ready_i = 1'b0;
    for (int s = 0; s < 3; s++) start_w[s] = 1'b0;

    test_reset();
    test_d12_round_trip();
    test_d12_reduction();
    test_d1_pattern();
    test_d8_backpressure();
    test_reset_mid_frame();
    test_back_to_back();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/byte_decode_stream.md
# byte_decode_stream

Streaming ML-KEM ByteDecode_d stage. It accepts one frame of 32·D bytes on an 8-bit valid/ready input stream and emits the 256 D-bit coefficients on a valid/ready output stream, one coefficient per handshake. It sits directly downstream of the byte-serialised output of byte_encode, for example in decapsulation ciphertext and key parsing. For D=12 every coefficient is reduced mod q.

## Interface
- D, 12: bits per coefficient, legal 1..12.
- OUT_WIDTH, 16: coefficient output width, ≥ D; upper bits zero.
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous, active-low reset.
- start_i  in  1  begin a frame; honoured only in IDLE.
- in_data_i  in  8  input byte.
- in_valid_i  in  1  input byte valid.
- in_ready_o  out  1  byte accepted when in_valid_i && in_ready_o.
- coef_o  out  OUT_WIDTH  decoded coefficient.
- coef_idx_o  out  8  index 0..255 of coef_o.
- coef_last_o  out  1  coef_idx_o == 255 while coef_valid_o.
- coef_valid_o  out  1  coefficient available.
- coef_ready_i  in  1  coefficient consumed when coef_valid_o && coef_ready_i.
- busy_o  out  1  state == RUN.
- done_o  out  1  one-cycle pulse, frame complete.

## Operation
- Bit order is LSB-first, matching the encoder.
  - Byte j bit k is stream bit 8j+k.
  - Coefficient i is stream bits [iD +: D], bit 0 is the LSB.
- Internal state:
  - bit buffer buf_q of D+8 bits and bit_cnt (0..D+8).
  - byte_cnt (0..32·D).
  - coef_cnt (0..256).
- FSM states:
  - IDLE: in_ready_o=0, coef_valid_o=0. start_i → RUN; clear buf_q, bit_cnt, byte_cnt, coef_cnt.
  - RUN: stream processing as below. The last coefficient handshake moves the FSM to IDLE and asserts done_o the next cycle.
  - start_i in RUN is ignored.
- Input acceptance: in_ready_o = RUN && byte_cnt < 32·D && bit_cnt ≤ D.
- Output: coef_valid_o = RUN && bit_cnt ≥ D.
  - raw = buf_q[D-1:0].
  - D<12: coef_o = raw.
  - D=12: coef_o = raw ≥ 3329 ? raw − 3329 : raw. One conditional subtraction suffices because raw < 2·q.
- Push only: the byte is written at buf_q[bit_cnt +: 8]; bit_cnt += 8.
- Pop only: buf_q >>= D; bit_cnt −= D; coef_cnt++.
- Push and pop in the same cycle: shift first, then write the byte at position bit_cnt−D; bit_cnt += 8−D.
- The in_ready_o bound guarantees bit_cnt never exceeds D+8 and leaves no deadlock: bit_cnt < D always permits a push.
- At frame end byte_cnt reaches 32·D exactly as bit_cnt reaches 0 after the 256th pop. No residual bits remain for any D.
- Extra in_valid_i after 32·D bytes is not accepted (in_ready_o=0) and stays pending for the next frame.

## Timing
- Reset values: FSM=IDLE, all counters 0, buf_q=0, every output 0.
- start_i sampled at edge t: busy_o and in_ready_o are high from t+1.
- First coef_valid_o:
  - D≤8: one cycle after the first byte is accepted.
  - D=12: one cycle after the second byte is accepted.
- coef_o, coef_idx_o and coef_last_o are held stable while coef_valid_o && !coef_ready_i.
- Throughput with no stalls: max(32·D, 256) cycles per frame plus startup.
- done_o pulses in the cycle after the coef_last_o handshake. busy_o is low in that same cycle; a new start_i is accepted there.
- Reset asserted mid-frame: the next cycle is IDLE with all outputs 0 and partial data discarded.

## Structure
- Shared package mlkem_pkg holds:
  - Q = 3329 and N = 256.
  - the coefficient width typedef coef_t of 12 bits.
  - the FSM state enum (IDLE, RUN).
- Sub-module cond_sub_q performs the combinational single conditional subtraction of q. It is also reused by other decode and decompress stages.
- Expected size: about 150–200 lines of RTL.

## Test plan
- D=12 round trip:
  - Stimulus: bytes from byte_encode of f[i] = i mod 3329 (i=0..255), in_valid_i always 1, coef_ready_i always 1.
  - Response: coef_o = i at each coef_idx_o = i; 384 bytes accepted; done_o pulses exactly once.
- D=12 reduction:
  - Stimulus: all bytes 0xFF.
  - Response: every coef_o = 766; coef_last_o only at index 255.
- D=1:
  - Stimulus: bytes 0x55 ×32.
  - Response: coef_o alternates 1,0,1,0… starting at index 0.
- D=8 backpressure:
  - Stimulus: bytes 0..255; coef_ready_i toggles 1,0 and in_valid_i follows a random pattern.
  - Response: coef_o = index; outputs held stable while stalled; no byte lost or duplicated.
- Reset mid-frame:
  - Stimulus: rst_ni low for one cycle after 100 coefficients, then a new full frame.
  - Response: next cycle is IDLE with all outputs 0; the new frame decodes from index 0 correctly.
- Start ignored in RUN:
  - Stimulus: start_i held high for the whole D=8 frame.
  - Response: counters are not cleared; exactly 256 coefficients; done_o pulses and a second frame starts the following cycle.
